// File: rtl/uart_line_arbiter_if.sv
// Byte-stream bundle between the two UART receive paths, the arbiter and
// the PC-facing serializer. The master view belongs to the arbiter: it
// drives the source ready signals, the output byte and the grant status.
// The slave view is the surrounding fabric (sources, serializer, monitors).
interface uart_line_arbiter_if;
    logic [7:0] croc_data;
    logic       croc_valid;
    logic       croc_ready;
    logic [7:0] stm_data;
    logic       stm_valid;
    logic       stm_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] grant;
    logic       timeout_evt;

    modport master (
        input  croc_data, croc_valid, stm_data, stm_valid, tx_ready,
        output croc_ready, stm_ready, tx_data, tx_valid, grant, timeout_evt
    );

    modport slave (
        output croc_data, croc_valid, stm_data, stm_valid, tx_ready,
        input  croc_ready, stm_ready, tx_data, tx_valid, grant, timeout_evt
    );
endinterface

// File: rtl/uart_line_arbiter.sv
// uart_line_arbiter: shares the PC UART transmit path between the CROC
// console and the STM32 monitor link with line granularity. A granted
// source keeps the link until it sends 0x0A, reaches MAX_LINE bytes, or
// stays silent for IDLE_TIMEOUT cycles. Ties in IDLE go round-robin.
// A single output register decouples the sources from the serializer and
// drains on its own, independent of ownership.
//
// Optional build macro: UART_ARB_TAG_EN -- each grant first emits a tag
// byte ('C' for CROC, 'S' for STM32) through an extra TAG state.
module uart_line_arbiter #(
    parameter int IDLE_TIMEOUT = 20000,
    parameter int MAX_LINE     = 256
) (
    input  logic                clk,
    input  logic                rst,
    uart_line_arbiter_if.master bus
);

    localparam int BW = $clog2(MAX_LINE + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT);

    localparam logic [BW-1:0] CNT_MAX   = BW'(MAX_LINE);
    localparam logic [BW-1:0] CNT_LAST  = BW'(MAX_LINE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);
    localparam logic [7:0]    NEWLINE   = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef UART_ARB_TAG_EN
        S_TAG  = 2'd1,
`endif
        S_PASS = 2'd2
    } state_t;

`ifdef UART_ARB_TAG_EN
    localparam state_t     GRANT_NEXT = S_TAG;
    localparam logic [7:0] TAG_CROC   = 8'h43;
    localparam logic [7:0] TAG_STM    = 8'h53;
`else
    localparam state_t     GRANT_NEXT = S_PASS;
`endif

    state_t          state_r;
    logic [1:0]      grant_r;
    logic            last_stm_r;
    logic [BW-1:0]   byte_cnt_r;
    logic [IW-1:0]   idle_cnt_r;
    logic [7:0]      tx_data_r;
    logic            tx_valid_r;

    logic            or_free_s;
    logic            in_pass_s;
    logic            owner_valid_s;
    logic [7:0]      owner_data_s;
    logic            accept_s;
    logic            timeout_hit_s;

    // Decode owner handshake, output-register availability and timeout
    always_comb begin
        or_free_s = !tx_valid_r || bus.tx_ready;
        in_pass_s = (state_r == S_PASS);
        if (grant_r[0]) begin
            owner_valid_s = bus.croc_valid;
            owner_data_s  = bus.croc_data;
        end else begin
            owner_valid_s = bus.stm_valid;
            owner_data_s  = bus.stm_data;
        end
        accept_s      = in_pass_s && owner_valid_s && or_free_s;
        timeout_hit_s = in_pass_s && !owner_valid_s && (idle_cnt_r == IDLE_LAST);
    end

    assign bus.croc_ready  = in_pass_s && grant_r[0] && or_free_s;
    assign bus.stm_ready   = in_pass_s && grant_r[1] && or_free_s;
    assign bus.timeout_evt = timeout_hit_s;
    assign bus.tx_data     = tx_data_r;
    assign bus.tx_valid    = tx_valid_r;
    assign bus.grant       = grant_r;

    // Ownership FSM, line counters and output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            grant_r    <= 2'b00;
            last_stm_r <= 1'b1;
            byte_cnt_r <= '0;
            idle_cnt_r <= '0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            // The output register empties whenever the serializer takes it;
            // a load below overrides this in the same cycle.
            if (bus.tx_ready) begin
                tx_valid_r <= 1'b0;
            end else begin
                tx_valid_r <= tx_valid_r;
            end

            case (state_r)
                S_IDLE: begin
                    if (bus.croc_valid && (!bus.stm_valid || last_stm_r)) begin
                        grant_r    <= 2'b01;
                        byte_cnt_r <= '0;
                        idle_cnt_r <= '0;
                        state_r    <= GRANT_NEXT;
                    end else if (bus.stm_valid) begin
                        grant_r    <= 2'b10;
                        byte_cnt_r <= '0;
                        idle_cnt_r <= '0;
                        state_r    <= GRANT_NEXT;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
`ifdef UART_ARB_TAG_EN
                S_TAG: begin
                    if (or_free_s) begin
                        tx_data_r  <= grant_r[0] ? TAG_CROC : TAG_STM;
                        tx_valid_r <= 1'b1;
                        state_r    <= S_PASS;
                    end else begin
                        state_r    <= S_TAG;
                    end
                end
`endif
                S_PASS: begin
                    if (accept_s) begin
                        tx_data_r  <= owner_data_s;
                        tx_valid_r <= 1'b1;
                        idle_cnt_r <= '0;
                        if (byte_cnt_r != CNT_MAX) begin
                            byte_cnt_r <= byte_cnt_r + BW'(1);
                        end else begin
                            byte_cnt_r <= byte_cnt_r;
                        end
                        // End of line or line-length cap: hand the link back.
                        if ((owner_data_s == NEWLINE) || (byte_cnt_r == CNT_LAST)) begin
                            grant_r    <= 2'b00;
                            last_stm_r <= grant_r[1];
                            state_r    <= S_IDLE;
                        end else begin
                            state_r    <= S_PASS;
                        end
                    end else if (!owner_valid_s) begin
                        if (timeout_hit_s) begin
                            grant_r    <= 2'b00;
                            last_stm_r <= grant_r[1];
                            state_r    <= S_IDLE;
                        end else begin
                            idle_cnt_r <= idle_cnt_r + IW'(1);
                        end
                    end else begin
                        // Owner valid but output register busy: wait.
                        state_r <= S_PASS;
                    end
                end
                default: begin
                    grant_r <= 2'b00;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
